// File: rtl/fpu_cmd_sequencer_pkg.sv
// Shared types and constants for the FPU command sequencer: FSM states,
// completion status codes, serial word indices and the command record.
package fpu_seq_pkg;

  localparam int unsigned FPU_DATA_W = 16;
  localparam int unsigned FPU_OP_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_WAIT,
    S_REPORT
  } seq_state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] WI_A    = 2'd0;
  localparam logic [1:0] WI_B    = 2'd1;
  localparam logic [1:0] WI_OP   = 2'd2;
  localparam logic [1:0] WI_EXEC = 2'd3;

  typedef struct packed {
    logic [FPU_OP_W-1:0]   op;
    logic [FPU_DATA_W-1:0] b;
    logic [FPU_DATA_W-1:0] a;
  } fpu_cmd_t;

  localparam int unsigned CMD_W = $bits(fpu_cmd_t);

  // Serial word presented to the FPU for a given word index.
  function automatic logic [FPU_DATA_W-1:0] word_sel(input fpu_cmd_t c, input logic [1:0] idx);
    case (idx)
      WI_A:    return c.a;
      WI_B:    return c.b;
      WI_OP:   return {{(FPU_DATA_W-FPU_OP_W){1'b0}}, c.op};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_cmd_sequencer_if.sv
// Command / FPU / completion signal bundle for the sequencer.
// master = upstream + FPU side, slave = the sequencer itself.
interface fpu_cmd_sequencer_if;
  import fpu_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [FPU_DATA_W-1:0] cmd_a;
  logic [FPU_DATA_W-1:0] cmd_b;
  logic [FPU_OP_W-1:0]   cmd_op;
  logic                  fpu_start;
  logic [FPU_DATA_W-1:0] fpu_data;
  logic                  fpu_ready;
  logic                  fpu_error;
  logic                  busy;
  logic                  done_valid;
  logic [1:0]            done_status;
  logic [7:0]            done_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, fpu_ready, fpu_error,
    input  cmd_ready, fpu_start, fpu_data, busy, done_valid, done_status, done_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, fpu_ready, fpu_error,
    output cmd_ready, fpu_start, fpu_data, busy, done_valid, done_status, done_count
  );

endinterface

// File: rtl/fpu_cmd_sequencer_fifo.sv
// Synchronous FIFO with occupancy counter. Push while full and pop while
// empty are ignored; simultaneous push/pop keeps occupancy unchanged.
module fpu_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Buffers FPU commands and serialises each one as four strobed words
// (A, B, OP, EXEC) separated by gap cycles, then waits for FPU completion,
// error or timeout and reports a one-cycle done pulse with status.
module fpu_cmd_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  fpu_cmd_sequencer_if.slave  bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t            r_state;
  logic [1:0]            r_idx;
  fpu_cmd_t              r_hold;
  logic [TW-1:0]         r_tmo;
  logic                  r_start;
  logic [FPU_DATA_W-1:0] r_data;
  logic                  r_dv;
  logic [1:0]            r_status;
  logic [7:0]            r_count;

  fpu_cmd_t              w_push_data;
  fpu_cmd_t              w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;

  assign w_push_data.op = bus.cmd_op;
  assign w_push_data.b  = bus.cmd_b;
  assign w_push_data.a  = bus.cmd_a;
  assign w_pop          = (r_state == S_IDLE) && !w_empty;

  fpu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.cmd_valid),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.cmd_ready   = !w_full;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.fpu_start   = r_start;
  assign bus.fpu_data    = r_data;
  assign bus.done_valid  = r_dv;
  assign bus.done_status = r_status;
  assign bus.done_count  = r_count;

  // Sequencer FSM; strobe/data/done outputs are loaded on the edge entering
  // the state they belong to, so they are valid for exactly that state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= WI_A;
      r_hold   <= '0;
      r_tmo    <= '0;
      r_start  <= 1'b0;
      r_data   <= '0;
      r_dv     <= 1'b0;
      r_status <= ST_OK;
      r_count  <= '0;
    end else begin
      r_start <= 1'b0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_hold  <= w_head;
            r_idx   <= WI_A;
            r_start <= 1'b1;
            r_data  <= word_sel(w_head, WI_A);
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: r_state <= S_GAP;
        S_GAP: begin
          if (r_idx != WI_EXEC) begin
            r_idx   <= r_idx + 2'd1;
            r_start <= 1'b1;
            r_data  <= word_sel(r_hold, r_idx + 2'd1);
            r_state <= S_DRIVE;
          end else begin
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.fpu_error || bus.fpu_ready || (r_tmo == TW'(TIMEOUT_CYCLES))) begin
            r_dv     <= 1'b1;
            r_count  <= r_count + 8'd1;
            r_state  <= S_REPORT;
            r_status <= bus.fpu_error ? ST_ERR : (bus.fpu_ready ? ST_OK : ST_TIMEOUT);
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_REPORT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_cmd_sequencer.md
FPU_CMD_SEQUENCER -- requirements
Module: fpu_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles before a command is aborted.
REQ-002 Parameter FIFO_DEPTH, default 4: number of command entries buffered.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at a rising edge.
REQ-007 cmd_a  input  16  operand A.
REQ-008 cmd_b  input  16  operand B.
REQ-009 cmd_op  input  2  FPU opcode 0..3.
REQ-010 fpu_start  output  1  one-cycle strobe qualifying fpu_data, to FPU start.
REQ-011 fpu_data  output  16  serial word to FPU data.
REQ-012 fpu_ready  input  1  FPU completion level.
REQ-013 fpu_error  input  1  FPU error level.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done_valid  output  1  one-cycle pulse per finished command.
REQ-016 done_status  output  2  00 ok, 01 FPU error, 10 timeout; valid only with done_valid.
REQ-017 done_count  output  8  finished-command counter, wraps 255->0.

Function
REQ-018 Commands SHALL be stored in a FIFO_DEPTH-entry FIFO of {cmd_op, cmd_b, cmd_a}; cmd_ready SHALL equal !full.
REQ-019 A push and a pop in the same cycle SHALL both occur with occupancy unchanged; push while full SHALL be refused.
REQ-020 FSM states SHALL be IDLE, DRIVE, GAP, WAIT, REPORT, with a 2-bit word index (0=A, 1=B, 2=OP, 3=EXEC).
REQ-021 IDLE with FIFO non-empty SHALL pop the head into a holding register, clear the word index, and enter DRIVE.
REQ-022 DRIVE SHALL last one cycle with fpu_start=1 and fpu_data = cmd_a, cmd_b, {14'b0,cmd_op}, or 16'h0000 by index; DRIVE->GAP always.
REQ-023 GAP SHALL last one cycle with fpu_start=0 and fpu_data=0; GAP->DRIVE with index+1 if index<3, else GAP->WAIT.
REQ-024 Resulting fpu_start cycles relative to the pop cycle t: t+1, t+3, t+5, t+7; WAIT first active at t+9.
REQ-025 fpu_ready/fpu_error SHALL be ignored outside WAIT.
REQ-026 WAIT SHALL increment a timeout counter each cycle; fpu_error=1 -> REPORT status 01 (error beats ready when both high); else fpu_ready=1 -> status 00; else counter reaching TIMEOUT_CYCLES -> status 10.
REQ-027 REPORT SHALL last one cycle: done_valid=1, done_status set, done_count+1; REPORT->IDLE.
REQ-028 Back-to-back commands: minimum pop-to-pop spacing SHALL be 11 cycles (pop, 8 drive/gap, >=1 WAIT, REPORT).
REQ-029 fpu_start, fpu_data, done_valid, done_status SHALL be registered outputs.

Reset
REQ-030 With rst=0 at a rising edge: state IDLE, FIFO empty, word index 0, timeout counter 0, done_count 0.
REQ-031 Output reset values: cmd_ready=1 after release, fpu_start=0, fpu_data=0, busy=0, done_valid=0, done_status=00.
REQ-032 Reset mid-operation SHALL abort the in-flight command with no done_valid and discard all queued commands.

Structure
REQ-033 Package fpu_seq_pkg SHALL hold the state enum, status codes (ST_OK, ST_ERR, ST_TIMEOUT), the word-index constants, and FPU_DATA_W=16, FPU_OP_W=2.
REQ-034 The FIFO SHALL be a sub-module fpu_cmd_fifo (parameterised width/depth, push/pop/full/empty); the FSM resides in the top.

Verification
REQ-035 Single command A=16'h3C00, B=16'h4000, op=1; fpu_ready raised 3 cycles into WAIT -> fpu_data 3C00, 4000, 0001, 0000 on strobes t+1/3/5/7; done_valid with status 00, done_count=1.
REQ-036 fpu_error and fpu_ready both high in the first WAIT cycle -> status 01.
REQ-037 TIMEOUT_CYCLES=8, FPU never responds -> done_valid at WAIT-entry+9 with status 10; next command then starts normally.
REQ-038 Push 5 commands back-to-back while FPU stalls -> cmd_ready low after 4 entries accepted (plus 1 in flight); all commands later issued in order.
REQ-039 Assert rst during the GAP after word B -> next cycle fpu_start=0, busy=0, cmd_ready=1, no done_valid; FIFO empty.
REQ-040 256 completed commands -> done_count wraps to 0.
